// File: rtl/clock_div_pkg.sv
// rtl/clock_div_pkg.sv - shared defaults for the programmable clock divider
package clock_div_pkg;

    localparam int CNT_W_DEF     = 28;
    localparam int RESET_DIV_DEF = 200000;
    localparam int NUM_CH_MAX    = 16;
    // A divisor of zero parks the channel with all outputs low.
    localparam int DIV_HALT      = 0;

endpackage

// File: rtl/clock_div_chan.sv
// rtl/clock_div_chan.sv - one divider channel with shadowed divisor (tick logic under CLOCK_DIV_PROG_TICK_EN)
module clock_div_chan
    import clock_div_pkg::*;
#(
    parameter int CNT_W     = CNT_W_DEF,
    parameter int RESET_DIV = RESET_DIV_DEF
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             enable_i,
    input  logic [CNT_W-1:0] divisor_i,
    input  logic             update_i,
    input  logic             sync_i,
    output logic             clock_o,
    output logic             tick_o,
    output logic             pending_o
);

    localparam logic [CNT_W-1:0] RST_VAL  = CNT_W'(RESET_DIV);
    localparam logic [CNT_W-1:0] HALT_VAL = CNT_W'(DIV_HALT);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] act_q, act_d;
    logic [CNT_W-1:0] shd_q, shd_d;
    logic             pend_q, pend_d;
    logic             clk_q, clk_d;
    logic             run;
    logic             nat_wrap;
    logic             apply;

    assign run      = enable_i && (act_q != HALT_VAL);
    // >= rather than == so a count left above a shrunken divisor still wraps.
    assign nat_wrap = run && (cnt_q >= act_q - CNT_W'(1));
    // Disable and sync are also period boundaries, so a waiting shadow may land there.
    assign apply    = pend_q && (!enable_i || sync_i || nat_wrap);

    always_comb begin
        clk_d  = run && (cnt_q < (act_q >> 1));
        cnt_d  = cnt_q + CNT_W'(1);
        act_d  = act_q;
        shd_d  = shd_q;
        pend_d = pend_q;
        if (!run || nat_wrap || sync_i || apply) begin
            cnt_d = '0;
        end
        if (apply) begin
            act_d  = shd_q;
            pend_d = 1'b0;
        end
        if (update_i) begin
            shd_d  = divisor_i;
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q  <= '0;
            act_q  <= RST_VAL;
            shd_q  <= RST_VAL;
            pend_q <= 1'b0;
            clk_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            act_q  <= act_d;
            shd_q  <= shd_d;
            pend_q <= pend_d;
            clk_q  <= clk_d;
        end
    end

`ifdef CLOCK_DIV_PROG_TICK_EN
    logic tick_q;

    // Only a natural wrap ticks; a sync alone restarts the period silently.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= nat_wrap;
        end
    end

    assign tick_o = tick_q;
`else
    assign tick_o = 1'b0;
`endif

    assign clock_o   = clk_q;
    assign pending_o = pend_q;

endmodule

// File: rtl/clock_div_prog.sv
// rtl/clock_div_prog.sv - NUM_CH programmable clock dividers sharing sync/reset (tick enabled by CLOCK_DIV_PROG_TICK_EN)
module clock_div_prog
    import clock_div_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int RESET_DIV = RESET_DIV_DEF
) (
    input  logic                    clock_in,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       enable,
    input  logic [NUM_CH*CNT_W-1:0] divisor,
    input  logic [NUM_CH-1:0]       update,
    input  logic                    sync,
    output logic [NUM_CH-1:0]       clock_out,
    output logic [NUM_CH-1:0]       tick,
    output logic [NUM_CH-1:0]       pending
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        clock_div_chan #(
            .CNT_W     (CNT_W),
            .RESET_DIV (RESET_DIV)
        ) u_chan (
            .clk_i     (clock_in),
            .reset_i   (reset),
            .enable_i  (enable[i]),
            .divisor_i (divisor[i*CNT_W +: CNT_W]),
            .update_i  (update[i]),
            .sync_i    (sync),
            .clock_o   (clock_out[i]),
            .tick_o    (tick[i]),
            .pending_o (pending[i])
        );
    end

endmodule
